pe_array_search: RTL



---
 rtl/me_pkg.sv | 31 +++
 rtl/sum_tree.sv | 49 ++++
 rtl/pe_array_search.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/me_pkg.sv
// Shared helpers and types for the motion-estimation SAD engine.
package me_pkg;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Width of a full TB x TB sum of absolute differences.
    function automatic int sad_width(input int tb_length, input int pix_w);
        return pix_w + clog2(tb_length * tb_length);
    endfunction

    // Width of a motion-vector component (0 .. SW-TB).
    function automatic int mv_width(input int sw_length, input int tb_length);
        return clog2(sw_length - tb_length + 1);
    endfunction

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/sum_tree.sv
// Pipelined binary adder tree: N unsigned PIX_W inputs, one register stage
// per level, result width grows one bit per level.
module sum_tree
    import me_pkg::*;
#(
    parameter int N     = 64,
    parameter int PIX_W = 8,
    localparam int LVLS  = clog2(N),
    localparam int OUT_W = PIX_W + LVLS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*PIX_W-1:0] din,
    output logic [OUT_W-1:0]   sum
);

    genvar gi;
    for (gi = 0; gi <= LVLS; gi++) begin : g_lvl
        localparam int W   = PIX_W + gi;
        localparam int CNT = N >> gi;
        logic [W-1:0] node [CNT];

        if (gi == 0) begin : g_leaf
            // Unpack the flat input bus into the leaf level.
            always_comb begin
                for (int k = 0; k < CNT; k++) begin
                    node[k] = din[k*PIX_W +: PIX_W];
                end
            end
        end else begin : g_add
            // One registered level: pairwise sums of the level below.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < CNT; k++) begin
                        node[k] <= '0;
                    end
                end else begin
                    for (int k = 0; k < CNT; k++) begin
                        node[k] <= {1'b0, g_lvl[gi-1].node[2*k]}
                                 + {1'b0, g_lvl[gi-1].node[2*k+1]};
                    end
                end
            end
        end
    end

    assign sum = g_lvl[LVLS].node[0];

endmodule

// File: rtl/pe_array_search.sv
// Full-search SAD engine: template held in a TB x TB array, search window
// streamed through a row-delay chain, one SAD per candidate and on-chip
// minimum tracking with a start/done handshake.
module pe_array_search
    import me_pkg::*;
#(
    parameter int TB_LENGTH = 8,
    parameter int SW_LENGTH = 32,
    parameter int PIX_W     = 8,
    localparam int SAD_W = sad_width(TB_LENGTH, PIX_W),
    localparam int MV_W  = mv_width(SW_LENGTH, TB_LENGTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             en_tb,
    input  logic [PIX_W-1:0] pel_tb,
    input  logic             en_sw,
    input  logic [PIX_W-1:0] pel_sw,
    output logic [SAD_W-1:0] sad,
    output logic             sad_valid,
    output logic [MV_W-1:0]  sad_mvx,
    output logic [MV_W-1:0]  sad_mvy,
    output logic             busy,
    output logic             done,
    output logic [SAD_W-1:0] best_sad,
    output logic [MV_W-1:0]  best_mvx,
    output logic [MV_W-1:0]  best_mvy
);

    localparam int NPIX    = TB_LENGTH * TB_LENGTH;
    localparam int SUM_LAT = clog2(NPIX) + 1;
    localparam int CW      = clog2(SW_LENGTH);
    localparam int DCW     = clog2(SUM_LAT + 1);
    // Window taps span TB-1 full rows plus TB pixels of the newest row.
    localparam int CHAIN   = (TB_LENGTH - 1) * SW_LENGTH + TB_LENGTH;

    state_e            state_q, state_d;
    logic [CW-1:0]     col_q, col_d, row_q, row_d;
    logic [DCW-1:0]    cnt_q, cnt_d;
    logic              start_acc, tag;
    logic [MV_W-1:0]   tag_mvx, tag_mvy;

    logic [PIX_W-1:0]  tmpl_q  [NPIX];
    logic [PIX_W-1:0]  chain_q [CHAIN];
    logic [NPIX*PIX_W-1:0] absdiff;
    logic [SAD_W-1:0]  tree_sum;

    logic              vld_q [SUM_LAT];
    logic [MV_W-1:0]   mvx_q [SUM_LAT];
    logic [MV_W-1:0]   mvy_q [SUM_LAT];

    logic [SAD_W-1:0]  best_sad_q;
    logic [MV_W-1:0]   best_mvx_q, best_mvy_q;

    assign tag_mvx = MV_W'(col_q - CW'(TB_LENGTH - 1));
    assign tag_mvy = MV_W'(row_q - CW'(TB_LENGTH - 1));

    // Next state, raster counters and candidate tagging.
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        cnt_d     = cnt_q;
        start_acc = 1'b0;
        tag       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = SEARCH;
                    col_d     = '0;
                    row_d     = '0;
                    start_acc = 1'b1;
                end
            end
            SEARCH: begin
                if (en_sw) begin
                    tag = (col_q >= CW'(TB_LENGTH - 1)) && (row_q >= CW'(TB_LENGTH - 1));
                    if (col_q == CW'(SW_LENGTH - 1)) begin
                        col_d = '0;
                        if (row_q == CW'(SW_LENGTH - 1)) begin
                            state_d = DRAIN;
                            cnt_d   = DCW'(SUM_LAT);
                        end else begin
                            row_d = row_q + CW'(1);
                        end
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - DCW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM state and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
        end
    end

    // Template shift-in, raster order; frozen outside IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NPIX; i++) tmpl_q[i] <= '0;
        end else if (en_tb && (state_q == IDLE)) begin
            for (int i = 0; i < NPIX - 1; i++) tmpl_q[i] <= tmpl_q[i+1];
            tmpl_q[NPIX-1] <= pel_tb;
        end
    end

    // Search-window delay chain; index 0 is the newest pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHAIN; i++) chain_q[i] <= '0;
        end else if (en_sw) begin
            chain_q[0] <= pel_sw;
            for (int i = 1; i < CHAIN; i++) chain_q[i] <= chain_q[i-1];
        end
    end

    // PE array: window pixel (r,c) sits (TB-1-r) rows and (TB-1-c) pixels back.
    genvar gi;
    for (gi = 0; gi < NPIX; gi++) begin : g_pe
        localparam int TAP = (TB_LENGTH - 1 - gi / TB_LENGTH) * SW_LENGTH
                           + (TB_LENGTH - 1 - gi % TB_LENGTH);
        logic [PIX_W-1:0] w_px, t_px;
        assign w_px = chain_q[TAP];
        assign t_px = tmpl_q[gi];
        assign absdiff[gi*PIX_W +: PIX_W] = (w_px > t_px) ? (w_px - t_px) : (t_px - w_px);
    end

    sum_tree #(
        .N     (NPIX),
        .PIX_W (PIX_W)
    ) u_sum_tree (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (absdiff),
        .sum   (tree_sum)
    );

    // Valid/mv pipe aligned with the adder tree; gaps insert a zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SUM_LAT; i++) begin
                vld_q[i] <= 1'b0;
                mvx_q[i] <= '0;
                mvy_q[i] <= '0;
            end
        end else if (start_acc) begin
            for (int i = 0; i < SUM_LAT; i++) begin
                vld_q[i] <= 1'b0;
                mvx_q[i] <= '0;
                mvy_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= tag;
            mvx_q[0] <= tag ? tag_mvx : '0;
            mvy_q[0] <= tag ? tag_mvy : '0;
            for (int i = 1; i < SUM_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                mvx_q[i] <= mvx_q[i-1];
                mvy_q[i] <= mvy_q[i-1];
            end
        end
    end

    // Best-match tracking; strict compare keeps the earliest raster candidate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_sad_q <= '1;
            best_mvx_q <= '0;
            best_mvy_q <= '0;
        end else if (start_acc) begin
            best_sad_q <= '1;
            best_mvx_q <= '0;
            best_mvy_q <= '0;
        end else if (vld_q[SUM_LAT-1] && (tree_sum < best_sad_q)) begin
            best_sad_q <= tree_sum;
            best_mvx_q <= mvx_q[SUM_LAT-1];
            best_mvy_q <= mvy_q[SUM_LAT-1];
        end
    end

    assign sad       = tree_sum;
    assign sad_valid = vld_q[SUM_LAT-1];
    assign sad_mvx   = mvx_q[SUM_LAT-1];
    assign sad_mvy   = mvy_q[SUM_LAT-1];
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign best_sad  = best_sad_q;
    assign best_mvx  = best_mvx_q;
    assign best_mvy  = best_mvy_q;

endmodule
